root_layer_sequencer: RTL

//  Central control unit at the quadtree root, LOCAL port. Parametrised successor of the single-pass root FSM.

---
 rtl/root_layer_sequencer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/root_layer_sequencer.sv
// Quadtree-root LOCAL-port sequencer: forwards host config writes as CONFIG flits and drives a
// multi-layer CALC / FIN_BROADCAST / FIN_COMP handshake. Optional watchdog: define ROOT_SEQ_WATCHDOG_EN.
`ifndef ROUTER_INFO_CONFIG
`define ROUTER_INFO_CONFIG 4'h1
`endif
`ifndef ROUTER_INFO_CALC
`define ROUTER_INFO_CALC 4'h2
`endif
`ifndef ROUTER_INFO_FIN_BROADCAST
`define ROUTER_INFO_FIN_BROADCAST 4'h3
`endif
`ifndef ROUTER_INFO_FIN_COMP
`define ROUTER_INFO_FIN_COMP 4'h4
`endif

module root_layer_sequencer #(
  parameter int NUM_PE      = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int LAYER_WIDTH = 4,
  parameter int TIMEOUT_CYC = 4096,
  localparam int FW = 4 + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_en,
  input  logic [ADDR_WIDTH-1:0]  write_addr,
  input  logic [DATA_WIDTH-1:0]  write_data,
  output logic                   write_rdy,
  input  logic                   in_data_valid,
  input  logic [FW-1:0]          in_data,
  output logic                   upstream_credit,
  output logic                   out_data_valid,
  output logic [FW-1:0]          out_data,
  input  logic                   downstream_credit,
  output logic                   busy,
  output logic [LAYER_WIDTH-1:0] layer_idx,
  output logic                   done,
  output logic                   error,
  output logic                   timeout
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE + 1) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PE_LAST  = PW'(NUM_PE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BCAST, S_SEND_BCAST, S_WAIT_COMP, S_SEND_COMP, S_SEND_CALC
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          credits_q, credits_d;
  logic [PW-1:0]          pe_cnt_q, pe_cnt_d;
  logic [LAYER_WIDTH-1:0] layer_num_q, layer_num_d;
  logic [LAYER_WIDTH-1:0] layer_idx_q, layer_idx_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   upc_q;
  logic                   emit;
  logic [3:0]             f_info;
  logic [ADDR_WIDTH-1:0]  f_addr;
  logic [DATA_WIDTH-1:0]  f_data;
  logic [3:0]             in_info;
  logic                   can_send, wr_acc, fin_ok;
  logic [LAYER_WIDTH:0]   idx_next, layer_lim;
  logic                   unused_payload;
`ifdef ROOT_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);
  logic [WW-1:0]          wd_q, wd_d;
  logic                   timeout_q, timeout_d;
`endif

  // Fin flits carry no payload of interest; only the info field is decoded.
  assign unused_payload = ^in_data[FW-5:0];
  assign in_info   = in_data[FW-1:FW-4];
  assign can_send  = (credits_q != '0);
  assign write_rdy = (state_q == S_IDLE) && can_send;
  assign wr_acc    = write_en && write_rdy;
  assign idx_next  = {1'b0, layer_idx_q} + (LAYER_WIDTH+1)'(1);
  assign layer_lim = (layer_num_q == '0) ? (LAYER_WIDTH+1)'(1) : {1'b0, layer_num_q};
  assign fin_ok    = in_data_valid &&
                     (((state_q == S_WAIT_BCAST) && (in_info == `ROUTER_INFO_FIN_BROADCAST)) ||
                      ((state_q == S_WAIT_COMP)  && (in_info == `ROUTER_INFO_FIN_COMP)));

  always_comb begin
    state_d     = state_q;
    pe_cnt_d    = pe_cnt_q;
    layer_num_d = layer_num_q;
    layer_idx_d = layer_idx_q;
    done_d      = 1'b0;
    error_d     = error_q;
    credits_d   = credits_q;
    emit        = 1'b0;
    f_info      = 4'h0;
    f_addr      = '0;
    f_data      = '0;
`ifdef ROOT_SEQ_WATCHDOG_EN
    timeout_d   = timeout_q;
    wd_d        = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (wr_acc) begin
          if (write_addr == '0) begin
            layer_num_d = write_data[LAYER_WIDTH-1:0];
          end else if (write_addr == {ADDR_WIDTH{1'b1}}) begin
            emit        = 1'b1;
            f_info      = `ROUTER_INFO_CALC;
            layer_idx_d = '0;
            pe_cnt_d    = '0;
            error_d     = 1'b0;
`ifdef ROOT_SEQ_WATCHDOG_EN
            timeout_d   = 1'b0;
`endif
            state_d     = S_WAIT_BCAST;
          end else begin
            emit   = 1'b1;
            f_info = `ROUTER_INFO_CONFIG;
            f_addr = write_addr;
            f_data = write_data;
          end
        end
      end
      S_WAIT_BCAST, S_WAIT_COMP: begin
        if (fin_ok) begin
          if (pe_cnt_q == PE_LAST) begin
            pe_cnt_d = '0;
            state_d  = (state_q == S_WAIT_BCAST) ? S_SEND_BCAST : S_SEND_COMP;
          end else begin
            pe_cnt_d = pe_cnt_q + PW'(1);
          end
        end
`ifdef ROOT_SEQ_WATCHDOG_EN
        // Counter restarts on every counted fin; a silent PE array aborts the sequence.
        else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          pe_cnt_d  = '0;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
`endif
      end
      S_SEND_BCAST: begin
        if (can_send) begin
          emit    = 1'b1;
          f_info  = `ROUTER_INFO_FIN_BROADCAST;
          state_d = S_WAIT_COMP;
        end
      end
      S_SEND_COMP: begin
        if (can_send) begin
          emit   = 1'b1;
          f_info = `ROUTER_INFO_FIN_COMP;
          if (idx_next < layer_lim) begin
            layer_idx_d = idx_next[LAYER_WIDTH-1:0];
            state_d     = S_SEND_CALC;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_SEND_CALC: begin
        if (can_send) begin
          emit                     = 1'b1;
          f_info                   = `ROUTER_INFO_CALC;
          f_data[LAYER_WIDTH-1:0]  = layer_idx_q;
          state_d                  = S_WAIT_BCAST;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Any flit that is not the fin expected in the current wait phase is dropped and flagged.
    if (in_data_valid && !fin_ok) error_d = 1'b1;

    if (emit && !downstream_credit)
      credits_d = credits_q - CW'(1);
    else if (!emit && downstream_credit && (credits_q < CRED_MAX))
      credits_d = credits_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      credits_q   <= CRED_MAX;
      pe_cnt_q    <= '0;
      layer_num_q <= '0;
      layer_idx_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      upc_q       <= 1'b0;
`ifdef ROOT_SEQ_WATCHDOG_EN
      wd_q        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      pe_cnt_q    <= pe_cnt_d;
      layer_num_q <= layer_num_d;
      layer_idx_q <= layer_idx_d;
      done_q      <= done_d;
      error_q     <= error_d;
      upc_q       <= in_data_valid;
`ifdef ROOT_SEQ_WATCHDOG_EN
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign out_data_valid  = emit;
  assign out_data        = emit ? {f_info, f_addr, f_data} : '0;
  assign upstream_credit = upc_q;
  assign busy            = (state_q != S_IDLE);
  assign layer_idx       = layer_idx_q;
  assign done            = done_q;
  assign error           = error_q;
`ifdef ROOT_SEQ_WATCHDOG_EN
  assign timeout         = timeout_q;
`else
  assign timeout         = 1'b0;
`endif

endmodule
